// File: rtl/ipsxb_qsgmii_pcs_rx_align.sv
// QSGMII receive lane aligner: finds port 0 from the K28.1 marker, de-interleaves
// the 4-byte word stream into per-port byte/k pairs and restores K28.1 to K28.5.
module ipsxb_qsgmii_pcs_rx_align #(
    parameter int unsigned LOCK_CNT     = 3,
    parameter int unsigned UNLOCK_CNT   = 4,
    parameter bit          CONVERT_K281 = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pcs_rxd_in,
    input  logic [3:0]  pcs_rxk_in,
    output logic [7:0]  p0_pcs_rxd,
    output logic [7:0]  p1_pcs_rxd,
    output logic [7:0]  p2_pcs_rxd,
    output logic [7:0]  p3_pcs_rxd,
    output logic        p0_pcs_rxk,
    output logic        p1_pcs_rxk,
    output logic        p2_pcs_rxk,
    output logic        p3_pcs_rxk,
    output logic        lane_aligned,
    output logic [1:0]  align_offset
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [3:0] LOCK_TH   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TH = 4'(UNLOCK_CNT);
    localparam logic [7:0] K28_1     = 8'h3C;
    localparam logic [7:0] K28_5     = 8'hBC;

    state_t           state_q, state_d;
    logic [1:0]       offset_q, offset_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       err_q, err_d;
    logic [31:0]      prev_d_q;
    logic [3:0]       prev_k_q;
    logic             aligned_q;
    logic [3:0][7:0]  port_d_q, port_d_d;
    logic [3:0]       port_k_q, port_k_d;

    logic [3:0] hit;
    logic       single_hit;
    logic [1:0] hit_lane;
    logic       on_lane;
    logic       off_lane;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hit[i] = pcs_rxk_in[i] && (pcs_rxd_in[8*i +: 8] == K28_1);
        end
        single_hit = 1'b1;
        hit_lane   = 2'd0;
        unique case (hit)
            4'b0001: hit_lane = 2'd0;
            4'b0010: hit_lane = 2'd1;
            4'b0100: hit_lane = 2'd2;
            4'b1000: hit_lane = 2'd3;
            default: single_hit = 1'b0;
        endcase
        on_lane  = single_hit && (hit_lane == offset_q);
        off_lane = (|hit) && !on_lane;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        good_d   = good_q;
        err_d    = err_q;
        unique case (state_q)
            SEARCH: begin
                if (single_hit) begin
                    offset_d = hit_lane;
                    good_d   = 4'd0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (on_lane) begin
                    if (good_q != 4'hF) good_d = good_q + 4'd1;
                    if (good_d >= LOCK_TH) begin
                        state_d = LOCKED;
                        err_d   = 4'd0;
                    end
                end else if (off_lane) begin
                    state_d = SEARCH;
                    good_d  = 4'd0;
                end
            end
            LOCKED: begin
                if (on_lane) begin
                    err_d = 4'd0;
                end else if (off_lane) begin
                    if (err_q != 4'hF) err_d = err_q + 4'd1;
                    if (err_d >= UNLOCK_TH) begin
                        state_d = SEARCH;
                        err_d   = 4'd0;
                        good_d  = 4'd0;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Port k takes byte j+k of {previous word, current word}; gated by the registered state.
    always_comb begin
        logic [63:0] win_d;
        logic [7:0]  win_k;
        int unsigned pos;
        win_d    = {pcs_rxd_in, prev_d_q};
        win_k    = {pcs_rxk_in, prev_k_q};
        port_d_d = '0;
        port_k_d = '0;
        pos      = 0;
        if (state_q == LOCKED) begin
            for (int k = 0; k < 4; k++) begin
                pos         = 32'(offset_q) + 32'(k);
                port_d_d[k] = win_d[8*pos +: 8];
                port_k_d[k] = win_k[pos];
            end
            if (CONVERT_K281 && port_k_d[0] && (port_d_d[0] == K28_1)) begin
                port_d_d[0] = K28_5;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= SEARCH;
            offset_q  <= 2'd0;
            good_q    <= 4'd0;
            err_q     <= 4'd0;
            prev_d_q  <= '0;
            prev_k_q  <= '0;
            aligned_q <= 1'b0;
            port_d_q  <= '0;
            port_k_q  <= '0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            good_q    <= good_d;
            err_q     <= err_d;
            prev_d_q  <= pcs_rxd_in;
            prev_k_q  <= pcs_rxk_in;
            aligned_q <= (state_d == LOCKED);
            port_d_q  <= port_d_d;
            port_k_q  <= port_k_d;
        end
    end

    assign lane_aligned = aligned_q;
    assign align_offset = offset_q;
    assign p0_pcs_rxd   = port_d_q[0];
    assign p1_pcs_rxd   = port_d_q[1];
    assign p2_pcs_rxd   = port_d_q[2];
    assign p3_pcs_rxd   = port_d_q[3];
    assign p0_pcs_rxk   = port_k_q[0];
    assign p1_pcs_rxk   = port_k_q[1];
    assign p2_pcs_rxk   = port_k_q[2];
    assign p3_pcs_rxk   = port_k_q[3];

endmodule

// File: doc/ipsxb_qsgmii_pcs_rx_align.md
Name: ipsxb_qsgmii_pcs_rx_align

Overview:
QSGMII receive-side lane aligner and de-interleaver. It sits after the SerDes 8b/10b decoder (32-bit/4-byte word per clk) and ahead of the four per-port SGMII PCS receive paths. It locates port 0 by the K28.1 marker carried only in the port-0 byte position, rotates the byte stream so each port gets its own byte/k pair, and restores K28.1 to K28.5 for port 0.

Parameters:
LOCK_CNT, 3, consecutive further K28.1 hits at the candidate lane needed to declare lock (1..15)
UNLOCK_CNT, 4, consecutive misplaced-K28.1 words in LOCKED needed to drop lock (1..15)
CONVERT_K281, 1, 1 = port-0 K28.1 (k=1, 8'h3C) output as K28.5 (k=1, 8'hBC); 0 = pass unchanged

Ports:
clk  in  1  core clock, one 32-bit word per cycle
rstn  in  1  async active-low reset
pcs_rxd_in  in  32  decoded bytes; lane i = [8i+7:8i], lane 0 earliest in time
pcs_rxk_in  in  4  k-flag per lane
p0_pcs_rxd .. p3_pcs_rxd  out  8 each  per-port byte
p0_pcs_rxk .. p3_pcs_rxk  out  1 each  per-port k-flag
lane_aligned  out  1  1 while state = LOCKED
align_offset  out  2  lane currently holding port 0

Behaviour:
- Reset (async, rstn=0): state SEARCH, offset 0, counters 0, previous-word register 0, all outputs 0. Release is synchronous with no further wait.
- hit[i] = pcs_rxk_in[i] & (pcs_rxd_in[8i+7:8i] == 8'h3C). The word is a single hit at lane j if exactly one hit bit is set. A multi-hit word counts as a misplaced hit. A word with no hits is neutral.
- Byte window: d1 = previous input word. With offset j, port k takes byte position j+k of the 8-byte sequence {d1 lanes 0..3, current lanes 0..3}. For j=0, ports 0..3 = d1 lanes 0..3. For j=3, port0 = d1 lane 3 and ports 1..3 = current lanes 0..2.
- Outputs are registered. A port-0 byte on pcs_rxd_in in cycle N appears on p0_pcs_rxd in cycle N+2. Other ports follow with the same grouping, updated every cycle.
- FSM:
  - SEARCH: on a single hit at lane j, latch offset=j, good_cnt=0, go to CHECK. Otherwise stay.
  - CHECK: single hit at offset increments good_cnt; when good_cnt reaches LOCK_CNT, go to LOCKED with err_cnt=0. A misplaced or multi hit goes to SEARCH and clears good_cnt. Neutral words hold.
  - LOCKED: a hit at offset clears err_cnt. A misplaced or multi hit increments err_cnt; when err_cnt reaches UNLOCK_CNT, go to SEARCH. Neutral words hold err_cnt. Offset never changes while LOCKED.
- lane_aligned and align_offset are registered, updated on the same edge as the state. align_offset holds the latched offset in every state.
- When state != LOCKED, all p*_pcs_rxd = 8'h00 and all p*_pcs_rxk = 0 (forced on the output register).
- Output gating uses the state registered on the same edge, so the first non-forced group appears on the cycle after lane_aligned rises. Forcing begins on the cycle after lane_aligned falls.
- K conversion (CONVERT_K281=1): applies only to port 0; K28.1 on any other port passes unchanged.
- Offset change (SEARCH to CHECK) takes effect on the next window with no glitch handling; outputs are forced in that interval anyway.
- good_cnt and err_cnt are 4-bit and saturate; they cannot wrap.

Test Plan:
- Reset mid-stream (rstn=0 while LOCKED) -> all outputs 0, lane_aligned=0, align_offset=0 within the reset. After release the FSM starts from SEARCH; send 4 aligned K28.1 words at lane 0 -> lane_aligned=1.
- Lane 0, LOCK_CNT=3: four words {p3=D5.6 8'hC5,k0; p2=8'hBC,k1; p1=8'hBC,k1; p0=8'h3C,k1} -> lane_aligned=1 after the 4th word. p0 then outputs 8'hBC/k1 and p1..p3 output their input bytes, 2-cycle latency.
- Offset 2: port-0 K28.1 in lane 2, followed by data bytes 8'h11/22/33 for ports 1..3 -> align_offset=2, lock reached. p1=8'h11, p2=8'h22, p3=8'h33 in the same output cycle.
- In CHECK, a word with K28.1 in lane 1 while offset=0 -> returns to SEARCH, lane_aligned stays 0, outputs stay 0.
- In LOCKED, UNLOCK_CNT=4: 3 misplaced words, 1 correct, 3 misplaced -> stays locked. A 4th consecutive misplaced word -> lane_aligned=0 and outputs forced to 0 the next cycle.
- CONVERT_K281=0 -> p0 outputs 8'h3C/k1. A multi-hit word (lanes 0 and 2) in SEARCH -> no transition.
